// File: rtl/add_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add.sv
// 4-bit ripple-carry adder: S = A + B + C_in, C4 = carry out of bit 3.
module add (
    input  logic       C_in,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       C4
);

    logic [4:0] c;

    assign c[0] = C_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign C4 = c[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer around one 4-bit adder.
// Operands are latched on start, then one nibble per clock is pushed through
// the adder LSB first, with C4 carried to the next nibble via a register.
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Index width just large enough to address any nibble base of the operand.
    localparam int IW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [2:0]       idx;
    logic [IW-1:0]    base;
    logic             last;

    logic [NIBBLE_W-1:0] add_a;
    logic [NIBBLE_W-1:0] add_b;
    logic [NIBBLE_W-1:0] add_s;
    logic                add_c4;

    // Bit offset of the current nibble; idx never exceeds NIBBLES-1 in RUN.
    assign base  = IW'({idx, 2'b00});
    assign last  = (idx == 3'(NIBBLES - 1));
    assign add_a = opa[base +: NIBBLE_W];
    assign add_b = opb[base +: NIBBLE_W];

    add u_add (
        .C_in (carry),
        .A    (add_a),
        .B    (add_b),
        .S    (add_s),
        .C4   (add_c4)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= 3'd0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1, so invert B and force carry-in.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= 3'd0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[base +: NIBBLE_W] <= add_s;
                    carry <= add_c4;
                    idx   <= idx + 3'd1;
                    if (last) begin
                        // Overflow: operand signs agree but the result sign differs.
                        cout  <= add_c4;
                        ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                 (add_s[NIBBLE_W-1] != opa[WIDTH-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench: a 16-bit instance for directed/random ops, and a
// 1-nibble instance for an exhaustive 4-bit sweep.
module tb_add_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // 16-bit instance
    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    add_seq_ctrl #(.NIBBLES(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .ovf(ovf16)
    );

    // 4-bit instance
    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    add_seq_ctrl #(.NIBBLES(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .ovf(ovf4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  input bit s, input bit c,
                                  output longint rs, output bit co, output bit ov);
        longint m, sa, sb, r;
        m  = longint'(1) << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            r  = sa - sb;
            co = (ua >= ub);
        end else begin
            r  = sa + sb + longint'(c);
            co = (ua + ub + longint'(c)) >= m;
        end
        ov = (r >= m / 2) || (r < -(m / 2));
        rs = r & (m - 1);
    endfunction

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input bit ts,
                         input bit tc, input bit poke);
        longint es;
        bit     eco, eov;
        model(16, longint'(ta), longint'(tb_), ts, tc, es, eco, eov);
        @(negedge clk);
        a16 = ta; b16 = tb_; sub16 = ts; cin16 = tc; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("busy_e0", 32'(busy16), 32'd1);
        chk("done_e0", 32'(done16), 32'd0);
        if (poke) begin
            // A start while running must be ignored.
            start16 = 1'b1; a16 = ~ta; b16 = ta; sub16 = ~ts; cin16 = ~tc;
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) start16 = 1'b0;
            if (k < 4) begin
                chk("busy_run", 32'(busy16), 32'd1);
                chk("done_run", 32'(done16), 32'd0);
            end else begin
                chk("done_pulse", 32'(done16), 32'd1);
                chk("busy_done", 32'(busy16), 32'd0);
                chk("sum16", 32'(sum16), 32'(es));
                chk("cout16", 32'(cout16), 32'(eco));
                chk("ovf16", 32'(ovf16), 32'(eov));
            end
        end
        @(posedge clk); #1;
        chk("done_drop", 32'(done16), 32'd0);
        chk("sum16_hold", 32'(sum16), 32'(es));
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input bit ts, input bit tc);
        longint es;
        bit     eco, eov;
        model(4, longint'(ta), longint'(tb_), ts, tc, es, eco, eov);
        @(negedge clk);
        a4 = ta; b4 = tb_; sub4 = ts; cin4 = tc; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("busy4_e0", 32'(busy4), 32'd1);
        @(posedge clk); #1;
        chk("done4", 32'(done4), 32'd1);
        chk("sum4", 32'(sum4), 32'(es));
        chk("cout4", 32'(cout4), 32'(eco));
        if (ts) chk("ovf4", 32'(ovf4), 32'(eov));
        @(posedge clk); #1;
        chk("done4_drop", 32'(done4), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_sum", 32'(sum16), 32'd0);
        chk("rst_cout", 32'(cout16), 32'd0);
        chk("rst_ovf", 32'(ovf16), 32'd0);
        chk("rst_sum4", 32'(sum4), 32'd0);
        rst = 1'b0;

        // Directed vectors
        run16(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run16(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        run16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        run16(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1);
        run16(16'h5000, 16'h0001, 1'b1, 1'b0, 1'b0);

        // Reset in the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy16), 32'd0);
        chk("abort_done", 32'(done16), 32'd0);
        chk("abort_sum", 32'(sum16), 32'd0);
        chk("abort_cout", 32'(cout16), 32'd0);
        chk("abort_ovf", 32'(ovf16), 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done16), 32'd0);
        end
        run16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);

        // Randomized operations, some with a stray start mid-run
        for (int i = 0; i < 40; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        // Exhaustive single-nibble sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    run4(4'(x), 4'(y), 1'b0, 1'(c));
        for (int i = 0; i < 16; i++)
            run4(4'($urandom), 4'($urandom), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-cycle sequencer that builds a WIDTH-bit adder/subtractor from the team's single 4-bit ripple adder `add` (ports C_in, A, B, S, C4). It latches two operands on a start pulse and streams one nibble per clock through `add`, least significant nibble first, chaining C4 into the next nibble's C_in through a carry register. It sits between a request source and the shared 4-bit adder datapath.

## Interface
- NIBBLES, default 4: operand width in nibbles; WIDTH = 4*NIBBLES (16 by default); legal range 1..8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B (cin ignored); sampled with start.
- cin  input  1  carry-in for add mode; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is final.
- sum  output  WIDTH  result; holds its value until the next accepted start.
- cout  output  1  final C4 (in sub mode, 1 = no borrow).
- ovf  output  1  signed overflow of the full WIDTH-bit operation.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE with start=1:
  - Latch a into opa.
  - Latch b into opb, or ~b when sub=1.
  - Load carry with cin, or 1 when sub=1.
  - Clear idx and sum; go to RUN.
- IDLE with start=0: hold all registers.
- RUN: drive the adder with A = opa nibble idx, B = opb nibble idx, C_in = carry. At each edge:
  - Write S into sum[4*idx+3:4*idx].
  - Load carry with C4.
  - Increment idx.
  - On the edge where idx = NIBBLES−1, capture cout = C4 and compute ovf from the top nibble (sign bits of opa/opb equal and different from the sum MSB); go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
- start outside IDLE is ignored; nothing is queued. Starts are accepted again from the cycle in which the FSM is back in IDLE.
- Arithmetic is modulo 2^WIDTH. idx is a 3-bit counter and does not wrap within a run.
- Reset mid-RUN or in DONE aborts the operation with no done pulse.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state=IDLE, idx=0, carry=0.
- Latency, with start sampled high at edge E0:
  - Nibble k is written at edge E(k+1).
  - After edge E(NIBBLES), the FSM is in DONE and done=1 for that cycle.
  - After edge E(NIBBLES+1), the FSM is in IDLE.
- Throughput: one operation per NIBBLES+2 cycles. A start held high continuously is accepted at each IDLE.
- busy rises the cycle after the accepting edge and falls when DONE is entered.
- sum, cout and ovf are registered outputs and are stable from the done cycle until the next accepted start.
- The adder path is combinational within one cycle: opa/opb/carry register → add → sum/carry register.

## Structure
- Shared package add_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - NIBBLE_W=4.
- One sub-module instance: the existing `add`, unmodified. All sequencing lives in add_seq_ctrl.
- Register nibble extraction by indexed part-select on opa/opb; no barrel shifter.

## Test plan
- Reset, then a=0x0000, b=0x0000, cin=0, sub=0 → sum=0x0000, cout=0, ovf=0; done exactly 4 cycles after the start edge, busy high 4 cycles.
- a=0xFFFF, b=0x0001, add → sum=0x0000, cout=1, ovf=0 (carry ripples through all nibbles). Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- sub=1: a=0x5000, b=0x0001 → sum=0x4FFF, cout=1. Then a=0x0000, b=0x0001 → sum=0xFFFF, cout=0, ovf=0.
- start pulsed again during RUN with different operands → ignored; the first result completes unchanged with a single done pulse.
- rst asserted at the second RUN cycle → next cycle busy=0, done=0, sum=0, state IDLE. A following 0x1234+0x4321 gives 0x5555 with normal latency.
- Exhaustive 4-bit sweep with NIBBLES=1 over all a, b and cin → sum and cout match a+b+cin.
